// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: states, opcodes and control encodings shared by the multicycle MIPS controller
package mips_mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BEQ, BNE, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  function automatic state_t decode_op(input logic [5:0] op, input state_t ill);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_RTYPE:     return EXEC;
      OP_BEQ:       return BEQ;
      OP_BNE:       return BNE;
      OP_ADDI:      return ADDIEX;
      OP_J:         return JUMP;
      default:      return ill;
    endcase
  endfunction
endpackage

// File: rtl/mips_mc_retire_ctr.sv
// mips_mc_retire_ctr: wrapping retired-instruction counter with sync clear and increment enable
module mips_mc_retire_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM; define MIPS_MC_TRAP_EN to halt on illegal opcodes
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCEn,
  output logic [CNT_W-1:0] RetireCount,
  output logic             Halt
);
`ifdef MIPS_MC_TRAP_EN
  localparam state_t ILL_S = HALT;
`else
  localparam state_t ILL_S = FETCH;
`endif
  state_t state_q, state_d;
  always_ff @(posedge Clk) state_q <= Rst ? FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = MemReady ? DECODE : FETCH;
      DECODE:  state_d = decode_op(Op, ILL_S);
      MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:   state_d = MemReady ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  // Reset forces every select and enable low in the same cycle.
  always_comb begin
    IorD = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    ALUOp = ALU_ADD;
    PCSrc = PC_ALU;
    IRWrite = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    PCEn = 1'b0;
    if (!Rst) begin
      case (state_q)
        FETCH: begin
          ALUSrcB = SRCB_4;
          IRWrite = MemReady;
          PCEn = MemReady;
        end
        DECODE: ALUSrcB = SRCB_IMM2;
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          IorD = 1'b1;
          MemWrite = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_FUNCT;
        end
        ALUWB: begin
          RegDst = 1'b1;
          RegWrite = 1'b1;
        end
        BEQ, BNE: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_SUB;
          PCSrc = PC_ALUOUT;
          PCEn = (state_q == BEQ) ? Zero : ~Zero;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCSrc = PC_JUMP;
          PCEn = 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef MIPS_MC_TRAP_EN
  assign Halt = (state_q == HALT);
`else
  assign Halt = 1'b0;
`endif
  mips_mc_retire_ctr #(.W(CNT_W)) u_retire (
    .clk(Clk),
    .rst(Rst),
    .inc((state_q != FETCH) && (state_d == FETCH)),
    .cnt(RetireCount)
  );
endmodule
